fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage, directly upstream of decode.
- Owns the program counter and issues word addresses to the instruction BRAM (1-cycle read latency, data valid only in the cycle after issue).
- Presents registered `inst`/`pc` to decode. Absorbs pipeline stalls with a one-entry skid buffer and applies branch/jump redirects from execute on `flush`.

Parameters:
- RESET_PC, 27'h0, byte address fetched first after reset (bits [1:0] must be 0)
- IMEM_AW, 25, instruction-memory word-address width (= 27 − 2)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  IMEM_AW  word address of request (byte PC[26:2])
- imem_en  out  1  request strobe; data returns next cycle
- imem_rdata  in  32  instruction word for request issued previous cycle
- n_stall  in  1  global advance enable (0 = whole pipe frozen)
- dec_nstall  in  1  decode load-use hazard release (0 = decode holding)
- flush  in  1  redirect request from execute, pulse
- redirect_pc  in  27  byte target, valid with flush
- inst  out  32  instruction to decode
- pc  out  27  byte PC of inst
- fetch_valid  out  1  inst is real (0 = bubble)

Behaviour:
- adv = n_stall & dec_nstall. Outputs load only when adv or flush.
- Reset (rst=0, async):
  - inst=32'h0 (NOP: op 000, rd x0), pc=0, fetch_valid=0
  - imem_en=0, buffer empty, state=FILL
  - issue PC register = RESET_PC
- State RUN (normal operation):
  - imem_en=1 with imem_addr = issue PC each cycle; inflight flag set, inflight_pc recorded.
  - If adv: output register loads the buffer entry if valid, otherwise the returning imem_rdata/inflight_pc. Issue PC += 4.
  - If !adv: outputs hold; issue PC holds; imem_en=0. A word returning this cycle goes into the buffer (buf_valid=1).
- Buffer is one entry and never overflows: only one request can be outstanding when adv drops, because no new issue happens while !adv.
- When adv returns with buf_valid=1: output takes the buffer, buf_valid clears, issue resumes at the held issue PC in the same cycle. No duplicate fetch, no lost word.
- State FILL (entered after reset and after flush):
  - First cycle: issue only. Outputs = bubble (inst=0, fetch_valid=0).
  - Next cycle: go to RUN.
- flush has priority over stall:
  - Issue PC = redirect_pc. Buffer and inflight are discarded.
  - Outputs = bubble next cycle; state → FILL.
  - Redirect penalty = 2 cycles of bubbles before the target reaches decode.
- flush together with !n_stall: flush still wins; the redirect is not lost.
- Issue PC wraps modulo 2^27 (PC 27'h7FFFFFC + 4 → 0).
- redirect_pc[1:0] is ignored (forced to 00).
- Reset asserted mid-stall or mid-FILL: all state clears immediately, async.

Optional Feature:
- Macro: FETCH_JMP_PREDECODE_EN.
- With macro defined:
  - When a word with op[2:0]=3'b111 loads into the output register with adv=1, next issue PC = {word[30:6],2'b00}.
  - The already-issued sequential request is squashed: one bubble output, fetch_valid=0.
  - Execute flush for that jump is still honoured and is harmless.
- Without macro: purely sequential fetch; all jumps are resolved by execute via flush.

Decomposition:
- Package fetch_pkg:
  - typedef pc_t (logic [26:0]), inst_t (logic [31:0])
  - constants NOP_INST=32'h0, OP_JMP=3'b111
  - enum fetch_state_t {FILL, RUN}
- Sub-module fetch_skid_buf: one-entry inst/pc buffer with valid, load, and consume strobes.
- Next-PC mux, FSM and output registers stay in fetch_stage.

Test Plan:
- Reset release, adv=1, memory returns word = address → cycle 1 bubble; cycle 2 inst=word@0, pc=0; then pc=4, 8, 12 consecutively, fetch_valid=1.
- dec_nstall=0 for 3 cycles while pc=8 presented → inst/pc hold at 8. Word@12 is buffered. On release: pc=12 then 16, no gap, no duplicate.
- flush with redirect_pc=27'h100 while stalled with buffer full → buffer dropped; 2 bubbles; then pc=0x100, 0x104.
- flush and n_stall=0 in the same cycle → redirect taken; pc=redirect target appears after 2 bubbles.
- Issue PC = 27'h7FFFFFC → next pc=0, imem_addr=0.
- With FETCH_JMP_PREDECODE_EN: word 32'h00000407 at pc=0x20 (op=111, target 0x40) → pc=0x20, one bubble, then pc=0x40. Without macro: pc=0x24 follows.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

   typedef logic [26:0] pc_t;
   typedef logic [31:0] inst_t;

   localparam inst_t      NOP_INST = 32'h0;
   localparam logic [2:0] OP_JMP   = 3'b111;

   typedef enum logic {
      FILL,
      RUN
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry inst/pc holding buffer for words returning during a stall
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  clear,
   input  logic  load,
   input  logic  consume,
   input  inst_t load_inst,
   input  pc_t   load_pc,
   output logic  valid,
   output inst_t buf_inst,
   output pc_t   buf_pc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid    <= 1'b0;
         buf_inst <= NOP_INST;
         buf_pc   <= '0;
      end else begin
         if (clear || consume) begin
            valid <= 1'b0;
         end else if (load) begin
            valid <= 1'b1;
         end
         if (load) begin
            buf_inst <= load_inst;
            buf_pc   <= load_pc;
         end
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, BRAM request, skid buffer, flush redirect
// Optional jump predecode at fetch is enabled by defining FETCH_JMP_PREDECODE_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter pc_t RESET_PC = 27'h0,
   parameter int  IMEM_AW  = 25
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IMEM_AW-1:0] imem_addr,
   output logic               imem_en,
   input  logic [31:0]        imem_rdata,
   input  logic               n_stall,
   input  logic               dec_nstall,
   input  logic               flush,
   input  logic [26:0]        redirect_pc,
   output logic [31:0]        inst,
   output logic [26:0]        pc,
   output logic               fetch_valid
);

   fetch_state_t state, state_nxt;
   pc_t          issue_pc, issue_pc_nxt, inflight_pc;
   logic         inflight, adv, issue, take_jmp;
   logic         out_load, out_valid_nxt;
   inst_t        out_inst_nxt;
   pc_t          out_pc_nxt;
   logic         buf_valid, buf_load, buf_consume;
   inst_t        buf_inst;
   pc_t          buf_pc;
   logic         unused_redirect_lsb;

   assign adv                 = n_stall & dec_nstall;
   assign imem_en             = issue & rst;
   assign imem_addr           = issue_pc[IMEM_AW+1:2];
   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      issue         = 1'b0;
      buf_load      = 1'b0;
      buf_consume   = 1'b0;
      out_load      = 1'b0;
      out_inst_nxt  = NOP_INST;
      out_pc_nxt    = '0;
      out_valid_nxt = 1'b0;
      take_jmp      = 1'b0;
      issue_pc_nxt  = issue_pc;
      if (flush) begin
         out_load     = 1'b1;
         issue_pc_nxt = {redirect_pc[26:2], 2'b00};
         state_nxt    = FILL;
      end else begin
         case (state)
            FILL: begin
               issue     = 1'b1;
               state_nxt = RUN;
            end
            RUN: begin
               issue = adv;
               if (adv) begin
                  out_load = 1'b1;
                  if (buf_valid) begin
                     buf_consume   = 1'b1;
                     out_inst_nxt  = buf_inst;
                     out_pc_nxt    = buf_pc;
                     out_valid_nxt = 1'b1;
                  end else if (inflight) begin
                     out_inst_nxt  = imem_rdata;
                     out_pc_nxt    = inflight_pc;
                     out_valid_nxt = 1'b1;
                  end
               end else begin
                  // no issue while stalled, so at most this one word needs parking
                  buf_load = inflight;
               end
            end
            default: state_nxt = FILL;
         endcase
`ifdef FETCH_JMP_PREDECODE_EN
         take_jmp = out_load & out_valid_nxt & (out_inst_nxt[2:0] == OP_JMP);
`endif
         if (take_jmp) begin
            issue_pc_nxt = {out_inst_nxt[30:6], 2'b00};
         end else if (issue) begin
            issue_pc_nxt = issue_pc + 27'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         inst        <= NOP_INST;
         pc          <= '0;
         fetch_valid <= 1'b0;
      end else begin
         issue_pc <= issue_pc_nxt;
         // a predecoded jump squashes the sequential request issued alongside it
         inflight <= issue & ~take_jmp;
         if (issue) begin
            inflight_pc <= issue_pc;
         end
         if (out_load) begin
            inst        <= out_inst_nxt;
            pc          <= out_pc_nxt;
            fetch_valid <= out_valid_nxt;
         end
      end
   end

   fetch_skid_buf u_skid (
      .clk       (clk),
      .rst       (rst),
      .clear     (flush),
      .load      (buf_load),
      .consume   (buf_consume),
      .load_inst (imem_rdata),
      .load_pc   (inflight_pc),
      .valid     (buf_valid),
      .buf_inst  (buf_inst),
      .buf_pc    (buf_pc)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a program-order model
module tb_fetch_stage;

   typedef struct packed {
      logic [26:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [24:0] imem_addr;
   logic        imem_en;
   logic [31:0] imem_rdata = 32'h0;
   logic        n_stall = 1'b1;
   logic        dec_nstall = 1'b1;
   logic        flush = 1'b0;
   logic [26:0] redirect_pc = 27'h0;
   logic [31:0] inst;
   logic [26:0] pc;
   logic        fetch_valid;

   int   n_checks = 0;
   int   n_fail = 0;
   int   consumed = 0;
   exp_t exp_q[$];
   logic [26:0] last_pc;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(27'h0), .IMEM_AW(25)) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_addr   (imem_addr),
      .imem_en     (imem_en),
      .imem_rdata  (imem_rdata),
      .n_stall     (n_stall),
      .dec_nstall  (dec_nstall),
      .flush       (flush),
      .redirect_pc (redirect_pc),
      .inst        (inst),
      .pc          (pc),
      .fetch_valid (fetch_valid)
   );

   function automatic logic [31:0] mem_word(input logic [26:0] a);
      return (a == 27'h20) ? 32'h00000407 : {5'b0, a};
   endfunction

   function automatic logic [26:0] prog_next(input logic [26:0] a);
`ifdef FETCH_JMP_PREDECODE_EN
      logic [31:0] w;
      w = mem_word(a);
      if (w[2:0] == 3'b111) return {w[30:6], 2'b00};
`endif
      return a + 27'd4;
   endfunction

   // BRAM: one-cycle latency, garbage when no request was issued
   always @(posedge clk) imem_rdata <= imem_en ? mem_word({imem_addr, 2'b00}) : $urandom;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic restart_stream(input logic [26:0] start);
      exp_t e;
      exp_q.delete();
      e.pc = start;
      e.inst = mem_word(start);
      exp_q.push_back(e);
      last_pc = start;
   endtask

   task automatic top_up();
      exp_t e;
      while (exp_q.size() < 8) begin
         last_pc = prog_next(last_pc);
         e.pc = last_pc;
         e.inst = mem_word(last_pc);
         exp_q.push_back(e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      top_up();
   endtask

   task automatic do_flush(input logic [26:0] tgt);
      flush = 1'b1;
      redirect_pc = tgt;
      restart_stream({tgt[26:2], 2'b00});
   endtask

   // monitor: pops the scoreboard whenever decode takes a real instruction
   logic [31:0] prev_inst;
   logic [26:0] prev_pc;
   logic        prev_valid;
   logic        prev_hold = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (prev_hold) begin
            check("hold_inst", {32'h0, inst}, {32'h0, prev_inst});
            check("hold_pc", {37'h0, pc}, {37'h0, prev_pc});
            check("hold_valid", {63'h0, fetch_valid}, {63'h0, prev_valid});
         end
         prev_hold = !(n_stall && dec_nstall) && !flush;
         prev_inst = inst;
         prev_pc = pc;
         prev_valid = fetch_valid;
         if (fetch_valid && n_stall && dec_nstall && !flush) begin
            consumed++;
            if (exp_q.size() == 0) begin
               check("sb_empty", 64'h1, 64'h0);
            end else begin
               e = exp_q.pop_front();
               check("sb_pc", {37'h0, pc}, {37'h0, e.pc});
               check("sb_inst", {32'h0, inst}, {32'h0, e.inst});
            end
         end
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic chk_out(input string name, input logic v, input logic [26:0] p);
      check({name, "_valid"}, {63'h0, fetch_valid}, {63'h0, v});
      if (v) check({name, "_pc"}, {37'h0, pc}, {37'h0, p});
      else check({name, "_inst"}, {32'h0, inst}, 64'h0);
   endtask

   initial begin
      int c0;
      logic [26:0] tgt;
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_imem_en", {63'h0, imem_en}, 64'h0);
      check("rst_valid", {63'h0, fetch_valid}, 64'h0);
      check("rst_inst", {32'h0, inst}, 64'h0);
      check("rst_pc", {37'h0, pc}, 64'h0);

      // release and sequential stream
      rst = 1'b1;
      restart_stream(27'h0);
      top_up();
      mon_en = 1'b1;
      step(); chk_out("fill", 1'b0, 27'h0);
      check("fill_addr", {39'h0, imem_addr}, 64'h1);
      step(); chk_out("first", 1'b1, 27'h0);
      step(); chk_out("seq4", 1'b1, 27'h4);
      step(); chk_out("seq8", 1'b1, 27'h8);

      // decode hazard for three cycles
      dec_nstall = 1'b0;
      repeat (3) begin step(); chk_out("stall8", 1'b1, 27'h8); end
      dec_nstall = 1'b1;
      step(); chk_out("unstall12", 1'b1, 27'hC);
      step(); chk_out("unstall16", 1'b1, 27'h10);

      // flush while stalled with the buffer occupied
      dec_nstall = 1'b0;
      step(); step();
      do_flush(27'h100);
      step(); flush = 1'b0; dec_nstall = 1'b1;
      chk_out("fl_b1", 1'b0, 27'h0);
      step(); chk_out("fl_b2", 1'b0, 27'h0);
      step(); chk_out("fl_t0", 1'b1, 27'h100);
      step(); chk_out("fl_t1", 1'b1, 27'h104);

      // flush with global stall, unaligned target
      n_stall = 1'b0;
      do_flush(27'h203);
      step(); flush = 1'b0; n_stall = 1'b1;
      chk_out("fs_b1", 1'b0, 27'h0);
      step(); chk_out("fs_b2", 1'b0, 27'h0);
      step(); chk_out("fs_t0", 1'b1, 27'h200);

      // PC wrap
      do_flush(27'h7FFFFFC);
      step(); flush = 1'b0;
      check("wrap_addr0", {39'h0, imem_addr}, 64'h1FFFFFF);
      step();
      check("wrap_addr1", {39'h0, imem_addr}, 64'h0);
      step(); chk_out("wrap_top", 1'b1, 27'h7FFFFFC);
      step(); chk_out("wrap_zero", 1'b1, 27'h0);

      // jump word at 0x20
      do_flush(27'h20);
      step(); flush = 1'b0;
      step(); step(); chk_out("jmp_at", 1'b1, 27'h20);
`ifdef FETCH_JMP_PREDECODE_EN
      step(); chk_out("jmp_bub", 1'b0, 27'h0);
      step(); chk_out("jmp_tgt", 1'b1, 27'h40);
`else
      step(); chk_out("jmp_seq", 1'b1, 27'h24);
`endif

      // randomized traffic
      c0 = consumed;
      repeat (2000) begin
         n_stall = ($urandom % 4) != 0;
         dec_nstall = ($urandom % 4) != 0;
         if (($urandom % 40) == 0) begin
            case ($urandom % 3)
               0: tgt = 27'($urandom_range(0, 15) * 4);
               1: tgt = 27'h7FFFFF0 | 27'($urandom % 16);
               default: tgt = 27'($urandom);
            endcase
            do_flush(tgt);
         end
         step();
         flush = 1'b0;
      end
      check("progress", {63'h0, (consumed - c0) > 200}, 64'h1);

      // async reset in the middle of a stall
      n_stall = 1'b1;
      dec_nstall = 1'b0;
      step(); step();
      mon_en = 1'b0;
      #2 rst = 1'b0;
      #1;
      check("mid_rst_valid", {63'h0, fetch_valid}, 64'h0);
      check("mid_rst_pc", {37'h0, pc}, 64'h0);
      check("mid_rst_en", {63'h0, imem_en}, 64'h0);
      step();
      dec_nstall = 1'b1;
      rst = 1'b1;
      restart_stream(27'h0);
      top_up();
      mon_en = 1'b1;
      step(); chk_out("rr_fill", 1'b0, 27'h0);
      step(); chk_out("rr_first", 1'b1, 27'h0);
      repeat (20) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
